// File: rtl/acc_csr_responder_if.sv
// IOb native request/response bundle between the CPU-side bus master and the
// accelerator control/status responder.
interface acc_csr_responder_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned STRB_W = DATA_W / 8
);
  logic              valid;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              ready;

  modport master (
    output valid, addr, wdata, wstrb,
    input  rdata, rvalid, ready
  );

  modport slave (
    input  valid, addr, wdata, wstrb,
    output rdata, rvalid, ready
  );
endinterface

// File: rtl/acc_csr_responder.sv
// Memory-mapped control/status block that configures, launches and times the
// int-sum accelerator and raises a level interrupt when a run completes.
module acc_csr_responder #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned STRB_W = DATA_W / 8
) (
  input  logic                clk_i,
  input  logic                arst_i,
  acc_csr_responder_if.slave  iob,
  output logic                acc_start_o,
  output logic [ADDR_W-1:0]   acc_input_addr_o,
  output logic [ADDR_W-1:0]   acc_output_addr_o,
  output logic [31:0]         acc_n_o,
  input  logic                acc_done_i,
  output logic                irq_o
);

  localparam logic [2:0] IDX_CTRL   = 3'd0;
  localparam logic [2:0] IDX_STATUS = 3'd1;
  localparam logic [2:0] IDX_IN     = 3'd2;
  localparam logic [2:0] IDX_OUT    = 3'd3;
  localparam logic [2:0] IDX_N      = 3'd4;
  localparam logic [2:0] IDX_CYCLES = 3'd5;

  logic [ADDR_W-1:0] in_addr, out_addr;
  logic [DATA_W-1:0] n_reg;
  logic [31:0]       counter, cycles, counter_inc;
  logic              irq_en, busy, done, err, done_prev;

  logic              wr, rd, ctrl_wr, status_wr, cfg_wr;
  logic              start_req, start_ok, done_edge, err_set;
  logic [2:0]        idx;
  logic [DATA_W-1:0] rd_mux;
  logic              unused_addr;

  function automatic logic [DATA_W-1:0] strobed(input logic [DATA_W-1:0] cur,
                                                input logic [DATA_W-1:0] wd,
                                                input logic [STRB_W-1:0] st);
    strobed = cur;
    for (int i = 0; i < int'(STRB_W); i++)
      if (st[i]) strobed[8*i +: 8] = wd[8*i +: 8];
  endfunction

  assign unused_addr = ^{iob.addr[ADDR_W-1:5], iob.addr[1:0]};
  assign idx         = iob.addr[4:2];
  assign wr          = iob.valid & (|iob.wstrb);
  assign rd          = iob.valid & ~(|iob.wstrb);
  assign ctrl_wr     = wr & (idx == IDX_CTRL) & iob.wstrb[0];
  assign status_wr   = wr & (idx == IDX_STATUS) & iob.wstrb[0];
  assign cfg_wr      = wr & ((idx == IDX_IN) | (idx == IDX_OUT) | (idx == IDX_N));
  assign start_req   = ctrl_wr & iob.wdata[0];
  assign start_ok    = start_req & ~busy;
  assign done_edge   = acc_done_i & ~done_prev & busy;
  assign err_set     = busy & (start_req | cfg_wr);
  assign counter_inc = (counter == 32'hFFFF_FFFF) ? counter : counter + 32'd1;
  assign irq_o       = irq_en & done;

  // Read mux samples pre-edge state, so a same-cycle done edge is not visible yet
  always_comb begin
    rd_mux = '0;
    case (idx)
      IDX_CTRL:   rd_mux[1]   = irq_en;
      IDX_STATUS: rd_mux[2:0] = {err, done, busy};
      IDX_IN:     rd_mux      = DATA_W'(in_addr);
      IDX_OUT:    rd_mux      = DATA_W'(out_addr);
      IDX_N:      rd_mux      = n_reg;
      IDX_CYCLES: rd_mux      = DATA_W'(cycles);
      default:    rd_mux      = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      iob.ready         <= 1'b1;
      iob.rvalid        <= 1'b0;
      iob.rdata         <= '0;
      acc_start_o       <= 1'b0;
      acc_input_addr_o  <= '0;
      acc_output_addr_o <= '0;
      acc_n_o           <= '0;
      in_addr           <= '0;
      out_addr          <= '0;
      n_reg             <= '0;
      counter           <= '0;
      cycles            <= '0;
      irq_en            <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
      done_prev         <= 1'b0;
    end else begin
      iob.ready   <= 1'b1;
      iob.rvalid  <= rd;
      iob.rdata   <= rd ? rd_mux : '0;
      acc_start_o <= start_ok;
      done_prev   <= acc_done_i;

      if (ctrl_wr) irq_en <= iob.wdata[1];

      // Configuration is frozen while a run is in flight
      if (cfg_wr && !busy) begin
        case (idx)
          IDX_IN:  in_addr  <= ADDR_W'(strobed(DATA_W'(in_addr), iob.wdata, iob.wstrb));
          IDX_OUT: out_addr <= ADDR_W'(strobed(DATA_W'(out_addr), iob.wdata, iob.wstrb));
          default: n_reg    <= strobed(n_reg, iob.wdata, iob.wstrb);
        endcase
      end

      if (start_ok) begin
        acc_input_addr_o  <= in_addr;
        acc_output_addr_o <= out_addr;
        acc_n_o           <= 32'(n_reg);
        busy              <= 1'b1;
        counter           <= '0;
      end else begin
        if (busy) counter <= counter_inc;
        if (done_edge) begin
          busy   <= 1'b0;
          cycles <= counter_inc;
        end
      end

      if (done_edge)                         done <= 1'b1;
      else if (start_ok)                     done <= 1'b0;
      else if (status_wr && iob.wdata[1])    done <= 1'b0;

      if (err_set)                           err <= 1'b1;
      else if (status_wr && iob.wdata[2])    err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_acc_csr_responder.sv
// Directed bench for acc_csr_responder: register map, start/done flow,
// busy protection, byte strobes, same-cycle events and reset mid-run.
module tb_acc_csr_responder;

  logic        clk = 1'b0;
  logic        arst;
  logic        acc_start;
  logic [31:0] acc_in, acc_out, acc_n;
  logic        acc_done;
  logic        irq;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  acc_csr_responder_if bus ();

  acc_csr_responder dut (
    .clk_i             (clk),
    .arst_i            (arst),
    .iob               (bus),
    .acc_start_o       (acc_start),
    .acc_input_addr_o  (acc_in),
    .acc_output_addr_o (acc_out),
    .acc_n_o           (acc_n),
    .acc_done_i        (acc_done),
    .irq_o             (irq)
  );

  // Called at a falling edge; request is accepted at the next rising edge
  task automatic bus_write(input logic [2:0] idx, input logic [31:0] data, input logic [3:0] strb);
    bus.valid = 1'b1;
    bus.addr  = {27'd0, idx, 2'b00};
    bus.wdata = data;
    bus.wstrb = strb;
    @(negedge clk);
    bus.valid = 1'b0;
    bus.wstrb = 4'h0;
    bus.wdata = 32'h0;
  endtask

  task automatic bus_read(input logic [2:0] idx, output logic [31:0] data, output logic rv);
    bus.valid = 1'b1;
    bus.addr  = {27'd0, idx, 2'b00};
    bus.wstrb = 4'h0;
    @(negedge clk);
    bus.valid = 1'b0;
    data = bus.rdata;
    rv   = bus.rvalid;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    logic        rv;
    arst = 1'b1; acc_done = 1'b0;
    bus.valid = 1'b0; bus.addr = '0; bus.wdata = '0; bus.wstrb = '0;
    repeat (2) @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    tests++; if (bus.ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", bus.ready); end
    tests++; if ({irq, acc_start, bus.rvalid} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b exp 000", {irq, acc_start, bus.rvalid}); end
    tests++; if ({acc_in, acc_out, acc_n} !== 96'h0) begin fails++; $display("FAIL reset_acc got %h exp 0", {acc_in, acc_out, acc_n}); end
    bus_read(3'd1, d, rv);
    tests++; if ({rv, d} !== {1'b1, 32'h0}) begin fails++; $display("FAIL reset_status got rv=%b %h exp rv=1 0", rv, d); end
    @(negedge clk);
    tests++; if ({bus.rvalid, bus.rdata} !== 33'h0) begin fails++; $display("FAIL rvalid_one_cycle got %b %h exp 0 0", bus.rvalid, bus.rdata); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    logic        rv;
    bus_write(3'd2, 32'h1234_5678, 4'hF);
    tests++; if (bus.rvalid !== 1'b0) begin fails++; $display("FAIL write_no_rvalid got %b exp 0", bus.rvalid); end
    bus_write(3'd7, 32'hFFFF_FFFF, 4'hF);
    bus_read(3'd2, d, rv);
    tests++; if ({rv, d} !== {1'b1, 32'h1234_5678}) begin fails++; $display("FAIL b2b_rd0 got rv=%b %h exp rv=1 12345678", rv, d); end
    bus_read(3'd7, d, rv);
    tests++; if ({rv, d} !== {1'b1, 32'h0}) begin fails++; $display("FAIL b2b_rd1_idx7 got rv=%b %h exp rv=1 0", rv, d); end
    bus_read(3'd6, d, rv);
    tests++; if ({rv, d} !== {1'b1, 32'h0}) begin fails++; $display("FAIL b2b_rd2_idx6 got rv=%b %h exp rv=1 0", rv, d); end
    @(negedge clk);
    tests++; if (bus.rvalid !== 1'b0) begin fails++; $display("FAIL b2b_end_rvalid got %b exp 0", bus.rvalid); end
  endtask

  task automatic test_start_done;
    logic [31:0] d;
    logic        rv;
    bus_write(3'd2, 32'h100, 4'hF);
    bus_write(3'd3, 32'h200, 4'hF);
    bus_write(3'd4, 32'd8, 4'hF);
    bus_write(3'd0, 32'h3, 4'h1);
    tests++; if (acc_start !== 1'b1) begin fails++; $display("FAIL start_pulse got %b exp 1", acc_start); end
    tests++; if ({acc_in, acc_out, acc_n} !== {32'h100, 32'h200, 32'd8}) begin fails++; $display("FAIL start_shadow got %h exp 100/200/8", {acc_in, acc_out, acc_n}); end
    bus_read(3'd1, d, rv);
    tests++; if (acc_start !== 1'b0) begin fails++; $display("FAIL start_one_cycle got %b exp 0", acc_start); end
    tests++; if ({rv, d} !== {1'b1, 32'h1}) begin fails++; $display("FAIL status_busy got rv=%b %h exp rv=1 1", rv, d); end
    repeat (19) @(negedge clk);
    acc_done = 1'b1;
    @(negedge clk);
    acc_done = 1'b0;
    bus_read(3'd1, d, rv);
    tests++; if (d !== 32'h2) begin fails++; $display("FAIL status_done got %h exp 2", d); end
    bus_read(3'd5, d, rv);
    tests++; if (d !== 32'd21) begin fails++; $display("FAIL cycles got %0d exp 21", d); end
    tests++; if (irq !== 1'b1) begin fails++; $display("FAIL irq_set got %b exp 1", irq); end
    bus_write(3'd1, 32'h2, 4'h1);
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_clear got %b exp 0", irq); end
    bus_read(3'd1, d, rv);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL status_w1c got %h exp 0", d); end
  endtask

  task automatic test_busy_protect;
    logic [31:0] d;
    logic        rv;
    bus_write(3'd0, 32'h1, 4'h1);
    @(negedge clk);
    bus_write(3'd4, 32'd99, 4'hF);
    bus_write(3'd0, 32'h1, 4'h1);
    tests++; if (acc_start !== 1'b0) begin fails++; $display("FAIL busy_no_restart got %b exp 0", acc_start); end
    tests++; if (acc_n !== 32'd8) begin fails++; $display("FAIL busy_acc_n got %0d exp 8", acc_n); end
    bus_read(3'd1, d, rv);
    tests++; if (d !== 32'h5) begin fails++; $display("FAIL busy_err_status got %h exp 5", d); end
    bus_read(3'd4, d, rv);
    tests++; if (d !== 32'd8) begin fails++; $display("FAIL busy_n_reg got %0d exp 8", d); end
    bus_write(3'd1, 32'h4, 4'h1);
    bus_read(3'd1, d, rv);
    tests++; if (d !== 32'h1) begin fails++; $display("FAIL err_w1c got %h exp 1", d); end
    acc_done = 1'b1;
    @(negedge clk);
    acc_done = 1'b0;
    bus_write(3'd1, 32'h2, 4'h1);
    bus_read(3'd1, d, rv);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL busy_run_end got %h exp 0", d); end
  endtask

  task automatic test_byte_strobe;
    logic [31:0] d;
    logic        rv;
    bus_write(3'd2, 32'h0, 4'hF);
    bus_write(3'd2, 32'hAABB_CCDD, 4'b0101);
    bus_read(3'd2, d, rv);
    tests++; if (d !== 32'h00BB_00DD) begin fails++; $display("FAIL byte_strobe got %h exp 00bb00dd", d); end
    tests++; if (acc_in !== 32'h100) begin fails++; $display("FAIL strobe_no_shadow got %h exp 100", acc_in); end
  endtask

  task automatic test_simultaneous;
    logic [31:0] d;
    logic        rv;
    // STATUS read coinciding with done edge returns pre-edge value
    bus_write(3'd0, 32'h1, 4'h1);
    acc_done = 1'b1;
    bus_read(3'd1, d, rv);
    acc_done = 1'b0;
    tests++; if (d !== 32'h1) begin fails++; $display("FAIL sim_read_pre_edge got %h exp 1", d); end
    bus_read(3'd1, d, rv);
    tests++; if (d !== 32'h2) begin fails++; $display("FAIL sim_read_post_edge got %h exp 2", d); end
    // done edge and DONE W1C together: set wins
    bus_write(3'd0, 32'h1, 4'h1);
    acc_done = 1'b1;
    bus_write(3'd1, 32'h2, 4'h1);
    acc_done = 1'b0;
    bus_read(3'd1, d, rv);
    tests++; if (d !== 32'h2) begin fails++; $display("FAIL sim_set_wins got %h exp 2", d); end
    // START together with completing edge is rejected
    bus_write(3'd0, 32'h1, 4'h1);
    acc_done = 1'b1;
    bus_write(3'd0, 32'h1, 4'h1);
    acc_done = 1'b0;
    tests++; if (acc_start !== 1'b0) begin fails++; $display("FAIL sim_start_rejected got %b exp 0", acc_start); end
    bus_read(3'd1, d, rv);
    tests++; if (d !== 32'h6) begin fails++; $display("FAIL sim_start_err got %h exp 6", d); end
    bus_write(3'd1, 32'h6, 4'h1);
  endtask

  task automatic test_reset_mid_run;
    logic [31:0] d;
    logic        rv;
    bus_write(3'd0, 32'h3, 4'h1);
    repeat (3) @(negedge clk);
    arst = 1'b1;
    #1;
    tests++; if ({acc_in, acc_out, acc_n} !== 96'h0) begin fails++; $display("FAIL midrst_acc got %h exp 0", {acc_in, acc_out, acc_n}); end
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    acc_done = 1'b1;
    @(negedge clk);
    acc_done = 1'b0;
    bus_read(3'd1, d, rv);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL midrst_status got %h exp 0", d); end
    tests++; if ({irq, acc_start, bus.ready} !== 3'b001) begin fails++; $display("FAIL midrst_flags got %b exp 001", {irq, acc_start, bus.ready}); end
    tests++; if ({acc_in, acc_out, acc_n} !== 96'h0) begin fails++; $display("FAIL midrst_acc_after got %h exp 0", {acc_in, acc_out, acc_n}); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_start_done();
    test_busy_protect();
    test_byte_strobe();
    test_simultaneous();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/acc_csr_responder.md
Name: acc_csr_responder

Overview:
- IOb-native responder that the CPU port addresses to configure and launch the int-sum accelerator.
- It replaces the testbench-driven start/input_addr/output_addr/N/done pins with a memory-mapped control/status register block.
- It drives the accelerator control inputs, tracks completion and measures run length.
- It raises a level interrupt on completion. It sits beside the bus controller, decoded on the CPU side.

Parameters:
- ADDR_W, 32, IOb address width; only addr[4:2] is decoded.
- DATA_W, 32, IOb data width; must be 32.
- STRB_W, DATA_W/8, write-strobe width.

Ports:
- clk_i  in  1  system clock
- arst_i  in  1  asynchronous active-high reset
- iob_valid_i  in  1  request valid
- iob_addr_i  in  ADDR_W  byte address
- iob_wdata_i  in  DATA_W  write data
- iob_wstrb_i  in  STRB_W  byte strobes; all-zero means read
- iob_rdata_o  out  DATA_W  read data
- iob_rvalid_o  out  1  read data valid
- iob_ready_o  out  1  request accepted
- acc_start_o  out  1  one-cycle start pulse to accelerator
- acc_input_addr_o  out  ADDR_W  latched input base address
- acc_output_addr_o  out  ADDR_W  latched output base address
- acc_n_o  out  32  latched element count
- acc_done_i  in  1  accelerator done (level or pulse)
- irq_o  out  1  completion interrupt

Behaviour:
- Reset (async, arst_i=1): every register and output is 0, including iob_rdata_o, iob_rvalid_o, acc_start_o, irq_o, busy, all config/shadow regs and the cycle counter. Exception: iob_ready_o is 1 after reset.
- Handshake:
  - iob_ready_o is held at 1; every valid request is accepted in its valid cycle.
  - Read: iob_rvalid_o=1 for exactly one cycle, the cycle after accept, with iob_rdata_o registered. iob_rdata_o returns to 0 when rvalid=0.
  - Write: produces no rvalid.
  - Back-to-back reads give back-to-back rvalid pulses.
- Register map (word index addr[4:2]):
  - 0 CTRL: W bit0 START (write-1 pulse, reads 0), bit1 IRQ_EN (RW).
  - 1 STATUS: R bit0 BUSY, bit1 DONE (sticky; write-1-clears), bit2 ERR (sticky; write-1-clears).
  - 2 IN_ADDR: RW.
  - 3 OUT_ADDR: RW.
  - 4 N: RW.
  - 5 CYCLES: RO.
  - 6-7: read 0, writes ignored.
- Write rules:
  - RW regs honour byte strobes.
  - CTRL and STATUS bits act only when wstrb[0]=1.
- Start:
  - Accept START=1 when BUSY=0. Next cycle acc_start_o=1 for one cycle.
  - In that same edge: IN_ADDR/OUT_ADDR/N copy into the shadow registers driving acc_*_o; BUSY<=1; DONE<=0; cycle counter <=0.
  - acc_*_o change only at a start.
- Busy protection: while BUSY=1, writes to IN_ADDR/OUT_ADDR/N and START=1 are ignored and set ERR. IRQ_EN and STATUS W1C remain writable.
- Cycle counter: increments each cycle while BUSY=1 and saturates at 0xFFFFFFFF.
- Done detection:
  - Rising edge of acc_done_i, using a registered previous value, counts only while BUSY=1.
  - On that edge: BUSY<=0, DONE<=1, CYCLES<=counter+1 (saturating).
  - Edges while idle are ignored.
- irq_o = IRQ_EN & DONE, driven from registers with no extra latency.
- Simultaneous events:
  - Done edge and DONE W1C in the same cycle: set wins, DONE=1.
  - START write in the same cycle as the completing done edge: rejected (BUSY still 1) and sets ERR.
  - Read of STATUS in the same cycle as a done edge returns the pre-edge value.
- Reset mid-run: outputs return to 0 immediately. A later done edge is ignored because BUSY=0.

Test Plan:
- Reset then read idx1 -> rvalid one cycle later, rdata=0. iob_ready_o=1; irq_o=0; acc_*_o=0.
- Write IN_ADDR=0x100, OUT_ADDR=0x200, N=8, CTRL=0x3 -> acc_start_o high for exactly 1 cycle. acc_input_addr_o=0x100, acc_output_addr_o=0x200, acc_n_o=8. STATUS=0x1.
- Same run, pulse acc_done_i 20 cycles after acc_start_o -> STATUS=0x2, CYCLES=21, irq_o=1. Write STATUS=0x2 -> irq_o=0, STATUS=0.
- While BUSY, write N=99 and CTRL=0x1 -> acc_n_o stays 8, no second start, STATUS=0x5. Write STATUS=0x4 -> ERR clears.
- Byte strobe: write IN_ADDR=0xAABBCCDD with wstrb=0b0101 over 0 -> reads 0x00BB00DD.
- Assert arst_i during BUSY, release, then pulse acc_done_i -> STATUS=0, irq_o=0, acc_start_o=0, all acc_*_o=0.
